regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  XLEN   32  register width in bits
  NREGS  32  register count; power of two, >=2
  NRD    2   number of read ports, >=1
  BYPASS 1   1 = same-cycle write-to-read forwarding; 0 = none
REQ-002 AW SHALL be derived as $clog2(NREGS).
REQ-003 Ports, one per line: name direction width meaning.
  clk        input   1         sole clock, rising edge
  rst        input   1         asynchronous, active-low reset
  init_done  output  1         high once the post-reset clearing sweep is complete
  we         input   1         write enable
  waddr      input   AW        write address (rd)
  wdata      input   XLEN      write data
  rsv_valid  input   1         reserve request: mark rsv_addr pending
  rsv_addr   input   AW        register to reserve
  raddr      input   NRD*AW    read addresses; port i at bits [i*AW +: AW]
  rdata      output  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN]
  rbusy      output  NRD       port i's register has a pending write

Function
REQ-004 The control FSM SHALL have two states: INIT and RUN.
REQ-005 On reset the FSM SHALL enter INIT with sweep counter = 0; init_done = 0.
REQ-006 In INIT, each rising edge SHALL write 0 to register[counter] and increment the counter.
REQ-007 The edge that clears register NREGS-1 SHALL move the FSM to RUN and set init_done = 1, so init_done rises exactly NREGS edges after reset release.
REQ-008 In INIT, we and rsv_valid SHALL be ignored, all rdata SHALL read 0, and all rbusy SHALL read 0.
REQ-009 In RUN, a write SHALL occur at the rising edge when we = 1 and waddr != 0; writes to address 0 SHALL be discarded.
REQ-010 Reads SHALL be combinational with zero latency; raddr = 0 SHALL return 0 on that port regardless of any other input.
REQ-011 When BYPASS = 1, in RUN, if we = 1 and waddr = raddr_i != 0, rdata_i SHALL equal wdata in the same cycle.
REQ-012 When BYPASS = 0, rdata_i SHALL return the stored value until the edge that commits the write.
REQ-013 The scoreboard SHALL hold one busy bit per register; busy[0] SHALL be constant 0.
REQ-014 In RUN, rsv_valid = 1 with rsv_addr != 0 SHALL set busy[rsv_addr] at the edge.
REQ-015 In RUN, a committed write SHALL clear busy[waddr] at the edge.
REQ-016 A simultaneous reserve and write to the same address SHALL leave busy set: the reservation wins.
REQ-017 rbusy_i SHALL equal busy[raddr_i], except that with BYPASS = 1 it SHALL read 0 while a same-cycle write to raddr_i is bypassed (REQ-011).
REQ-018 Multiple read ports addressing the same register SHALL each return identical data and identical busy state.

Reset
REQ-019 Asserting rst at any time, including mid-sweep or mid-write, SHALL immediately force: FSM = INIT, counter = 0, init_done = 0, all busy bits = 0.
REQ-020 Register contents are undefined while rst is asserted; the sweep SHALL restart from register 0 after reset is released.

Verification
REQ-021 Reset release with NREGS = 32 -> init_done = 0 for 31 edges and rises on the 32nd; every register then reads 0.
REQ-022 Write 0xDEADBEEF to x5 in RUN; read x5 on both ports the next cycle -> 0xDEADBEEF on both; write 0x1 to x0 -> x0 still reads 0.
REQ-023 BYPASS = 1: we = 1, waddr = 7, wdata = 0x1234, raddr0 = 7 in the same cycle -> rdata0 = 0x1234 combinationally; with BYPASS = 0 -> old value.
REQ-024 Reserve x3, then read x3 -> rbusy = 1; write x3 -> rbusy = 0 the next cycle; reserve and write x3 on the same edge -> rbusy stays 1.
REQ-025 Assert rst on sweep cycle 10, release it -> init_done = 0 and the sweep takes a full 32 edges again; busy bits read 0.
REQ-026 we and rsv_valid asserted during INIT -> no register or busy bit changes after init_done rises.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with post-reset clearing sweep and busy scoreboard
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t          state, state_next;
    logic [AW-1:0]   cnt, cnt_next;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic            run;
    logic            wr_en;
    logic            rsv_en;

    assign run       = (state == RUN);
    assign init_done = run;
    assign wr_en     = run && we && (waddr != '0);
    assign rsv_en    = run && rsv_valid && (rsv_addr != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == INIT) begin
            cnt_next = cnt + 1'b1;
            if (cnt == LAST)
                state_next = RUN;
        end
    end

    // Storage is deliberately not reset; the sweep clears it after reset release.
    always_ff @(posedge clk) begin
        if (state == INIT)
            regs[cnt] <= '0;
        else if (wr_en)
            regs[waddr] <= wdata;
    end

    // Reservation is applied after the write-clear so that it wins on a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            if (wr_en)
                busy[waddr] <= 1'b0;
            if (rsv_en)
                busy[rsv_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;

        assign ra  = raddr[i*AW +: AW];
        assign hit = (BYPASS != 0) && we && (waddr == ra);

        assign rdata[i*XLEN +: XLEN] = (!run || ra == '0) ? '0 :
                                       hit                ? wdata : regs[ra];
        assign rbusy[i] = run && (ra != '0) && !hit && busy[ra];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for regfile_mp, bypass and no-bypass instances side by side
module tb_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic                rsv_valid;
    logic [AW-1:0]       rsv_addr;
    logic [NRD*AW-1:0]   raddr;
    logic                init_done_a, init_done_b;
    logic [NRD*XLEN-1:0] rdata_a, rdata_b;
    logic [NRD-1:0]      rbusy_a, rbusy_b;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .init_done(init_done_a), .we(we), .waddr(waddr), .wdata(wdata),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .init_done(init_done_b), .we(we), .waddr(waddr), .wdata(wdata),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b)
    );

    always #5 clk = ~clk;

    logic [63:0] sb_q[$];
    string       tag_q[$];
    int          passed = 0;
    int          total  = 0;

    task automatic push(input string tag, input logic [63:0] exp);
        sb_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        logic [63:0] exp;
        string       tag;
        total++;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
            return;
        end
        exp = sb_q.pop_front();
        tag = tag_q.pop_front();
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                         input logic rv, input logic [AW-1:0] rva,
                         input logic [AW-1:0] ra1, input logic [AW-1:0] ra0);
        we = w; waddr = wa; wdata = wd; rsv_valid = rv; rsv_addr = rva; raddr = {ra1, ra0};
    endtask

    task automatic expect4(input string tag, input logic [63:0] da, input logic [1:0] ba,
                           input logic [63:0] db, input logic [1:0] bb);
        push({tag, "_rdata_a"}, da);
        push({tag, "_rbusy_a"}, 64'(ba));
        push({tag, "_rdata_b"}, db);
        push({tag, "_rbusy_b"}, 64'(bb));
    endtask

    task automatic check4();
        #1;
        pop_check(rdata_a);
        pop_check(64'(rbusy_a));
        pop_check(rdata_b);
        pop_check(64'(rbusy_b));
    endtask

    task automatic count_init(input string tag);
        int edges = 0;
        do begin
            @(posedge clk);
            edges++;
            #1;
        end while (!init_done_a && edges < 100);
        push({tag, "_edges"}, 64'd32);
        pop_check(64'(edges));
        push({tag, "_done_both"}, 64'd3);
        pop_check(64'({init_done_b, init_done_a}));
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        push("init_done_in_reset", 64'd0);
        #1 pop_check(64'({init_done_b, init_done_a}));

        // Sweep with write and reserve held on x9: both must be ignored.
        @(negedge clk);
        rst = 1'b1;
        drive(1, 9, 32'hFFFF_FFFF, 1, 9, 9, 9);
        expect4("init_reads", 64'd0, 2'b00, 64'd0, 2'b00);
        check4();
        count_init("sweep1");
        drive(0, 0, 0, 0, 0, 0, 0);

        for (int a = 0; a < NREGS; a++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, AW'(a), AW'(a));
            expect4($sformatf("cleared_x%0d", a), 64'd0, 2'b00, 64'd0, 2'b00);
            check4();
        end

        @(negedge clk);
        drive(1, 5, 32'hDEAD_BEEF, 0, 0, 5, 5);
        expect4("wr_x5_same", {32'hDEAD_BEEF, 32'hDEAD_BEEF}, 2'b00, 64'd0, 2'b00);
        check4();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 5, 5);
        expect4("rd_x5", {32'hDEAD_BEEF, 32'hDEAD_BEEF}, 2'b00, {32'hDEAD_BEEF, 32'hDEAD_BEEF}, 2'b00);
        check4();

        @(negedge clk);
        drive(1, 0, 32'h1, 0, 0, 0, 0);
        expect4("wr_x0_same", 64'd0, 2'b00, 64'd0, 2'b00);
        check4();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect4("rd_x0", 64'd0, 2'b00, 64'd0, 2'b00);
        check4();

        @(negedge clk);
        drive(1, 7, 32'h1234, 0, 0, 5, 7);
        expect4("bypass_x7", {32'hDEAD_BEEF, 32'h1234}, 2'b00, {32'hDEAD_BEEF, 32'h0}, 2'b00);
        check4();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 5, 7);
        expect4("rd_x7", {32'hDEAD_BEEF, 32'h1234}, 2'b00, {32'hDEAD_BEEF, 32'h1234}, 2'b00);
        check4();
        @(negedge clk);
        drive(1, 7, 32'h5678, 0, 0, 7, 7);
        expect4("overwrite_x7", {32'h5678, 32'h5678}, 2'b00, {32'h1234, 32'h1234}, 2'b00);
        check4();

        @(negedge clk);
        drive(0, 0, 0, 1, 3, 3, 3);
        expect4("rsv_x3_same", 64'd0, 2'b00, 64'd0, 2'b00);
        check4();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 3, 3);
        expect4("rsv_x3_busy", 64'd0, 2'b11, 64'd0, 2'b11);
        check4();
        @(negedge clk);
        drive(1, 3, 32'hAB, 0, 0, 3, 3);
        expect4("wr_x3_same", {32'hAB, 32'hAB}, 2'b00, 64'd0, 2'b11);
        check4();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 3, 3);
        expect4("wr_x3_clear", {32'hAB, 32'hAB}, 2'b00, {32'hAB, 32'hAB}, 2'b00);
        check4();

        @(negedge clk);
        drive(1, 3, 32'hCD, 1, 3, 0, 3);
        expect4("rsv_wr_same", {32'h0, 32'hCD}, 2'b00, {32'h0, 32'hAB}, 2'b00);
        check4();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 3);
        expect4("rsv_wins", {32'h0, 32'hCD}, 2'b01, {32'h0, 32'hCD}, 2'b01);
        check4();

        // Reset while busy[3] is set, then abort the sweep after 10 edges.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 3, 3);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        push("midsweep_reset_done", 64'd0);
        #1 pop_check(64'({init_done_b, init_done_a}));
        @(negedge clk);
        rst = 1'b1;
        count_init("sweep2");
        @(negedge clk);
        expect4("after_resweep_x3", 64'd0, 2'b00, 64'd0, 2'b00);
        check4();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
